dmem_arbiter: RTL and testbench

//  Shares the single-port 64-bit data SRAM between the CPU MEM stage and the external host/loader port.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arbiter_burst_addr_gen.sv | 70 +++++++
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned BEAT_BYTES = 8;
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_arbiter_burst_addr_gen.sv
// Host burst address generator: latches base/len/direction at grant,
// counts beats and flags the last one. Beat 0 address passes straight
// through from the request so the grant cycle can issue it.
module burst_addr_gen
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              we_in,
    output logic [ADDR_W-1:0] addr_c,
    output logic              last_c,
    output logic              we_c
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;

    // Next-state for the latched burst descriptor and beat counter
    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        we_d   = we_q;
        if (load) begin
            base_d = base_in;
            len_d  = len_in;
            we_d   = we_in;
            cnt_d  = LEN_W'(1);
        end else if (advance) begin
            cnt_d = cnt_q + LEN_W'(1);
        end
    end

    // Current beat address, direction and last-beat flag; adding whole beats keeps base[2:0]
    always_comb begin
        addr_c = base_q + (ADDR_W'(cnt_q) << BEAT_SHIFT);
        last_c = (cnt_q == len_q);
        we_c   = we_q;
        if (load) begin
            addr_c = base_in;
            last_c = (len_in == '0);
            we_c   = we_in;
        end
    end

    // Descriptor and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            we_q   <= we_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data SRAM between the CPU MEM stage and the
// host burst port. Optional stall-cycle counter enabled by DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [LEN_W-1:0]  ext_len,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_beat,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_done,
    output logic [31:0]       stall_cnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    owner_e            last_owner_q, last_owner_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              ext_rvalid_q, ext_rvalid_d;
    logic              ext_done_q, ext_done_d;
    logic              cpu_win, ext_win, ext_beat_c;
    logic              beat_last, beat_we;
    logic [ADDR_W-1:0] beat_addr;

    burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (ext_win),
        .advance (state_q == BURST),
        .base_in (ext_addr),
        .len_in  (ext_len),
        .we_in   (ext_we),
        .addr_c  (beat_addr),
        .last_c  (beat_last),
        .we_c    (beat_we)
    );

    // Same-cycle round-robin arbitration while idle; reset blocks any grant
    always_comb begin
        cpu_win = 1'b0;
        ext_win = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (cpu_req && (!ext_req || last_owner_q == OWN_EXT)) begin
                cpu_win = 1'b1;
            end else if (ext_req) begin
                ext_win = 1'b1;
            end
        end
    end

    // Next-state, owner tracking and beat issue
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        ext_beat_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_win) begin
                    last_owner_d = OWN_CPU;
                end
                if (ext_win) begin
                    last_owner_d = OWN_EXT;
                    ext_beat_c   = 1'b1;
                    if (!beat_last) begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                ext_beat_c = !rst;
                if (beat_last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // SRAM strobes and response bookkeeping
    always_comb begin
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_beat_c) begin
            mem_en    = 1'b1;
            mem_we    = beat_we;
            mem_addr  = beat_addr;
            mem_wdata = ext_wdata;
        end
        cpu_rvalid_d = cpu_win & ~cpu_we;
        ext_rvalid_d = ext_beat_c & ~beat_we;
        ext_done_d   = ext_beat_c & beat_last;
    end

    // FSM, owner and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_EXT;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
            ext_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_done_q   <= ext_done_d;
        end
    end

    // Reset also squashes responses already in flight
    assign cpu_stall  = cpu_req & ~cpu_win;
    assign ext_gnt    = ext_win;
    assign ext_beat   = ext_beat_c;
    assign cpu_rvalid = cpu_rvalid_q & ~rst;
    assign ext_rvalid = ext_rvalid_q & ~rst;
    assign ext_done   = ext_done_q & ~rst;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of CPU stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cpu_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter (builds with or without DMEM_ARB_PERF_EN).
module tb_dmem_arbiter;

`ifdef DMEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [63:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_stall, cpu_rvalid;
    logic [63:0] cpu_rdata;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [63:0] ext_addr = '0, ext_wdata = '0;
    logic [7:0]  ext_len = '0;
    logic        ext_gnt, ext_beat, ext_rvalid, ext_done;
    logic [63:0] ext_rdata;
    logic [31:0] stall_cnt;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [63:0] exp_addr_q[$];
    logic [63:0] exp_cpu_rd_q[$];
    logic [63:0] exp_ext_rd_q[$];
    int          exp_done_q[$];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_beat(ext_beat),
        .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_done(ext_done),
        .stall_cnt(stall_cnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rpat(input logic [63:0] a);
        return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    function automatic logic [63:0] wpat(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    // SRAM model: read word is a function of the address, one cycle later
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= rpat(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard whenever the DUT produces something
    always @(negedge clk) begin
        if (ext_beat) begin
            if (exp_addr_q.size() == 0) check("beat_unexpected", 64'(exp_addr_q.size()), 64'd1);
            else check("beat_addr", mem_addr, exp_addr_q.pop_front());
        end
        if (cpu_rvalid) begin
            if (exp_cpu_rd_q.size() == 0) check("cpu_rvalid_unexpected", 64'(exp_cpu_rd_q.size()), 64'd1);
            else check("cpu_rdata", cpu_rdata, exp_cpu_rd_q.pop_front());
        end
        if (ext_rvalid) begin
            if (exp_ext_rd_q.size() == 0) check("ext_rvalid_unexpected", 64'(exp_ext_rd_q.size()), 64'd1);
            else check("ext_rdata", ext_rdata, exp_ext_rd_q.pop_front());
        end
        if (ext_done) begin
            if (exp_done_q.size() == 0) check("ext_done_unexpected", 64'(exp_done_q.size()), 64'd1);
            else check("ext_done_cycle", 64'(cyc), 64'(exp_done_q.pop_front()));
        end
    end

    // Full host burst from IDLE; optionally a CPU read waits from beat 0 onward
    task automatic run_burst(input logic we, input logic [63:0] base, input int len,
                             input logic cpu_wait);
        ext_req = 1'b1; ext_we = we; ext_addr = base; ext_len = 8'(len);
        cpu_req = cpu_wait; cpu_we = 1'b0; cpu_addr = 64'h40;
        for (int i = 0; i <= len; i++) begin
            exp_addr_q.push_back(base + 64'(i) * 64'd8);
            if (!we) exp_ext_rd_q.push_back(rpat(base + 64'(i) * 64'd8));
        end
        exp_done_q.push_back(cyc + len + 1);
        for (int i = 0; i <= len; i++) begin
            if (i > 0) ext_req = 1'b0;
            ext_wdata = wpat(i);
            @(negedge clk);
            check("ext_gnt", 64'(ext_gnt), 64'(i == 0));
            check("ext_beat", 64'(ext_beat), 64'd1);
            check("beat_we", 64'(mem_we), 64'(we));
            if (we) check("beat_wdata", mem_wdata, wpat(i));
            check("burst_stall", 64'(cpu_stall), 64'(cpu_wait));
            step();
        end
        @(negedge clk);
        check("done_after_last", 64'(ext_done), 64'd1);
        check("no_beat_after_last", 64'(ext_beat), 64'd0);
        if (!we) check("last_rvalid_with_done", 64'(ext_rvalid), 64'd1);
        if (cpu_wait) begin
            check("cpu_gnt_after_burst", 64'(mem_en & ~mem_we), 64'd1);
            check("cpu_addr_after_burst", mem_addr, 64'h40);
            check("cpu_stall_released", 64'(cpu_stall), 64'd0);
            exp_cpu_rd_q.push_back(rpat(64'h40));
        end else begin
            check("idle_after_burst", 64'(mem_en), 64'd0);
        end
        step();
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_stall", 64'(cpu_stall), 64'd0);
        check("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
        check("rst_ext_done", 64'(ext_done), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        step();

        // CPU-only read at 0x10
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
        exp_cpu_rd_q.push_back(rpat(64'h10));
        @(negedge clk);
        check("cpu_rd_en", 64'(mem_en), 64'd1);
        check("cpu_rd_we", 64'(mem_we), 64'd0);
        check("cpu_rd_addr", mem_addr, 64'h10);
        check("cpu_rd_stall", 64'(cpu_stall), 64'd0);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_rvalid_next", 64'(cpu_rvalid), 64'd1);
        step();

        // CPU-only write at 0x20
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h20; cpu_wdata = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        check("cpu_wr_we", 64'(mem_we), 64'd1);
        check("cpu_wr_addr", mem_addr, 64'h20);
        check("cpu_wr_data", mem_wdata, 64'hDEAD_BEEF_0123_4567);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        check("cpu_wr_no_rvalid", 64'(cpu_rvalid), 64'd0);
        step();

        // Host write burst, 4 beats from 0x100
        run_burst(1'b1, 64'h100, 3, 1'b0);

        // Tie alternation: last owner is EXT, so CPU first, then EXT
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h30;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 64'h200; ext_len = 8'd0;
        exp_cpu_rd_q.push_back(rpat(64'h30));
        @(negedge clk);
        check("tie1_cpu_addr", mem_addr, 64'h30);
        check("tie1_no_gnt", 64'(ext_gnt), 64'd0);
        check("tie1_stall", 64'(cpu_stall), 64'd0);
        step();
        exp_addr_q.push_back(64'h200);
        exp_ext_rd_q.push_back(rpat(64'h200));
        exp_done_q.push_back(cyc + 1);
        @(negedge clk);
        check("tie2_gnt", 64'(ext_gnt), 64'd1);
        check("tie2_stall", 64'(cpu_stall), 64'd1);
        step();
        ext_req = 1'b0;
        exp_cpu_rd_q.push_back(rpat(64'h30));
        @(negedge clk);
        check("len0_done", 64'(ext_done), 64'd1);
        check("len0_rvalid", 64'(ext_rvalid), 64'd1);
        check("tie3_cpu_addr", mem_addr, 64'h30);
        check("tie3_stall", 64'(cpu_stall), 64'd0);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("tie3_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
        step();

        // 8-beat read burst with a CPU read waiting throughout
        run_burst(1'b0, 64'h400, 7, 1'b1);

        // Address wrap and preserved low bits
        run_burst(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1'b0);
        run_burst(1'b0, 64'h1005, 2, 1'b0);
        check("stall_cnt_total", 64'(stall_cnt), PERF ? 64'd9 : 64'd0);

        // Reset at beat 2 of a 6-beat read burst
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 64'h300; ext_len = 8'd5;
        exp_addr_q.push_back(64'h300);
        exp_ext_rd_q.push_back(rpat(64'h300));
        @(negedge clk);
        check("abort_gnt", 64'(ext_gnt), 64'd1);
        step();
        ext_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h50;
        exp_addr_q.push_back(64'h308);
        @(negedge clk);
        check("abort_beat1", 64'(ext_beat), 64'd1);
        check("abort_beat1_stall", 64'(cpu_stall), 64'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("abort_rst_no_beat", 64'(ext_beat), 64'd0);
        check("abort_rst_no_en", 64'(mem_en), 64'd0);
        check("abort_rst_no_rvalid", 64'(ext_rvalid), 64'd0);
        step();
        rst = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        check("abort_idle_no_beat", 64'(ext_beat), 64'd0);
        check("abort_no_done", 64'(ext_done), 64'd0);
        check("abort_stall_cnt", 64'(stall_cnt), 64'd0);
        step();
        cpu_req = 1'b1;
        exp_cpu_rd_q.push_back(rpat(64'h50));
        @(negedge clk);
        check("abort_cpu_gnt", 64'(mem_en), 64'd1);
        check("abort_cpu_stall", 64'(cpu_stall), 64'd0);
        check("abort_no_done2", 64'(ext_done), 64'd0);
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("abort_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
        step();

        repeat (3) step();
        check("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
        check("cpu_rd_q_drained", 64'(exp_cpu_rd_q.size()), 64'd0);
        check("ext_rd_q_drained", 64'(exp_ext_rd_q.size()), 64'd0);
        check("done_q_drained", 64'(exp_done_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
